prog_up_down_counter: RTL and testbench
=======================================

// Module: prog_up_down_counter
// PURPOSE
//  Parametrised up/down counter: runtime top limit, built-in clock prescaler,
//  synchronous parallel load, wrap or saturate mode, terminal-count pulse.
//  Next generation of the fixed 4-bit up/down counter.
//  Serves as the general time-base/event counter in the clock designs, e.g.
//  digit counters for displayed clocks chained via tc.
// PARAMETERS
//  WIDTH      8   count / limit / load_val width
//  DIV_WIDTH  16  prescaler divisor width
//  SATURATE   0   0 = wrap at bounds, 1 = hold at bounds
// PORTS
//  clk       in   1          rising-edge clock (single domain)
//  reset     in   1          asynchronous, active-low reset
//  en        in   1          count enable; prescaler and count hold when 0
//  up_down   in   1          1 = count up, 0 = count down
//  load      in   1          synchronous load strobe
//  load_val  in   WIDTH      value loaded on load
//  limit     in   WIDTH      top value; count range is 0..limit
//  div       in   DIV_WIDTH  prescale: one step every div+1 enabled cycles
//  count     out  WIDTH      current count (registered)
//  tc        out  1          terminal-count pulse (registered)
// BEHAVIOUR
//  - reset low (async, no clock needed): count=0, tc=0, prescaler=0.
//  - Prescaler: pre_cnt increments on en=1 cycles. tick=1 when pre_cnt==div,
//    and pre_cnt returns to 0 that cycle. div=0 gives a tick on every enabled
//    cycle. en=0 freezes pre_cnt. div changes apply from the current pre_cnt.
//    If pre_cnt>div after div is lowered, next cycle ticks and clears.
//  - Priority (per cycle): reset > load > tick step > hold.
//  - load=1: count <= min(load_val, limit); pre_cnt <= 0; tc <= 0.
//    Load works regardless of en.
//  - Step on tick, up_down=1:
//    - count>=limit: count<=0 (SATURATE=0) or limit (SATURATE=1); tc<=1.
//    - else count<=count+1.
//  - Step on tick, up_down=0:
//    - count==0: count<=limit (SATURATE=0) or 0 (SATURATE=1); tc<=1.
//    - else count<=count-1. This applies even if count>limit, after limit
//      was lowered.
//  - tc: one-cycle pulse, registered together with the bound update, so it is
//    high in the same cycle count shows the wrapped/held value.
//    - In SATURATE=1, tc pulses on every tick taken while at the bound.
//    - tc=0 on all non-tick cycles.
//  - limit=0: count stays 0; every tick is a bound event (tc pulse per tick).
//  - up_down is sampled only on tick cycles. Direction changes need no
//    settling; the next tick uses the new direction.
//  - Latency: div=0, en=1 -> count changes on every rising edge; load is
//    visible 1 cycle after the strobe.
//  - All arithmetic is unsigned WIDTH bits. No intermediate overflow, because
//    the bound check precedes the +1/-1.
// STRUCTURE
//  - Shared package udc_pkg:
//    - constants DIR_UP=1'b1, DIR_DOWN=1'b0
//    - MODE_WRAP=0, MODE_SAT=1
//    - default WIDTH / DIV_WIDTH
//  - One sub-module: tick_prescaler (clk, reset, en, clr, div -> tick),
//    parametrised by DIV_WIDTH. It is reusable by other clock blocks.
//  - The top holds the count register, the bound compare, the load mux and
//    the tc register.
// TESTING
//  1. reset low 20ns then high; en=1, up_down=1, div=0, limit=9
//     -> count 0,1..9,0; tc=1 only in the cycle count returns to 0.
//  2. count=0, up_down=0, limit=9, div=0 -> next edge count=9, tc=1;
//     then 8,7,... with tc=0.
//  3. div=3, en=1, up -> count advances every 4th edge; en=0 for 10 cycles
//     -> count and phase frozen, then resume exactly where stopped.
//  4. limit=9, load=1, load_val=12 -> count=9.
//     load on a tick cycle with load_val=5 -> count=5 (load wins), tc=0.
//  5. SATURATE=1, limit=15, up from 14 -> 15, then stays 15 with tc=1 on
//     each tick; down from 0 -> stays 0, tc=1 each tick.
//  6. reset pulled low between edges mid-count (count=7)
//     -> count=0 and tc=0 immediately, before any clk edge;
//     counting restarts from 0 after release.

Source files
------------

// File: rtl/udc_pkg.sv
// Shared constants for the up/down counter family and its prescaler.
package udc_pkg;

   localparam int unsigned DEF_WIDTH     = 8;
   localparam int unsigned DEF_DIV_WIDTH = 16;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam bit MODE_WRAP = 1'b0;
   localparam bit MODE_SAT  = 1'b1;

endpackage

// File: rtl/prog_up_down_counter_tick_prescaler.sv
// Enable-gated prescaler: one tick every div+1 enabled cycles.
// A lowered div takes effect at once; an overshot phase ticks and clears.
module tick_prescaler
   import udc_pkg::*;
#(
   parameter int unsigned DIV_WIDTH = DEF_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 clr,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] pre_cnt_q;
   logic [DIV_WIDTH-1:0] pre_cnt_d;
   logic                 at_div_c;

   always_comb begin
      at_div_c  = (pre_cnt_q >= div);
      pre_cnt_d = pre_cnt_q;
      if (clr) begin
         pre_cnt_d = '0;
      end else if (en) begin
         pre_cnt_d = at_div_c ? '0 : pre_cnt_q + DIV_WIDTH'(1);
      end
   end

   // Tick is combinational so the counter can step on the same edge.
   assign tick = en && !clr && at_div_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

endmodule

// File: rtl/prog_up_down_counter.sv
// Up/down counter with runtime limit, prescaler, parallel load,
// wrap/saturate bound handling and a registered terminal-count pulse.
module prog_up_down_counter
   import udc_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned DIV_WIDTH = DEF_DIV_WIDTH,
   parameter bit          SATURATE  = MODE_WRAP
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 up_down,
   input  logic                 load,
   input  logic [WIDTH-1:0]     load_val,
   input  logic [WIDTH-1:0]     limit,
   input  logic [DIV_WIDTH-1:0] div,
   output logic [WIDTH-1:0]     count,
   output logic                 tc
);

   logic             tick;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             tc_q;
   logic             tc_d;

   tick_prescaler #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (load),
      .div   (div),
      .tick  (tick)
   );

   // Bound check comes before +1/-1, so no overflow path exists.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (load) begin
         count_d = (load_val > limit) ? limit : load_val;
      end else if (tick) begin
         if (up_down == DIR_UP) begin
            if (count_q >= limit) begin
               count_d = (SATURATE == MODE_SAT) ? limit : '0;
               tc_d    = 1'b1;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == '0) begin
               count_d = (SATURATE == MODE_SAT) ? '0 : limit;
               tc_d    = 1'b1;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;

endmodule

// File: tb/tb_prog_up_down_counter.sv
// Bench for prog_up_down_counter: wrap and saturate instances share stimulus.
module tb_prog_up_down_counter;
   import udc_pkg::*;

   localparam int unsigned W  = 8;
   localparam int unsigned DW = 16;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic          en       = 1'b0;
   logic          up_down  = 1'b1;
   logic          load     = 1'b0;
   logic [W-1:0]  load_val = '0;
   logic [W-1:0]  limit    = 8'd9;
   logic [DW-1:0] div      = '0;
   logic [W-1:0]  cnt_w, cnt_s;
   logic          tc_w, tc_s;

   int n_tests = 0;
   int n_fail  = 0;

   int m_cnt [2];
   int m_pre [2];
   int m_tc  [2];

   typedef struct {
      logic          en;
      logic          ud;
      logic          ld;
      logic [W-1:0]  lv;
      logic [W-1:0]  lim;
      logic [DW-1:0] dv;
      int            cw;
      int            tw;
      int            cs;
      int            ts;
   } vec_t;

   vec_t tbl[$];

   prog_up_down_counter #(.WIDTH(W), .DIV_WIDTH(DW), .SATURATE(MODE_WRAP)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
      .load_val(load_val), .limit(limit), .div(div), .count(cnt_w), .tc(tc_w)
   );

   prog_up_down_counter #(.WIDTH(W), .DIV_WIDTH(DW), .SATURATE(MODE_SAT)) u_sat (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
      .load_val(load_val), .limit(limit), .div(div), .count(cnt_s), .tc(tc_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0;
         m_pre[i] = 0;
         m_tc[i]  = 0;
      end
   endtask

   // Index 0 models wrap mode, index 1 saturate mode.
   task automatic model_edge();
      int lim;
      int d;
      int lv;
      lim = int'(limit);
      d   = int'(div);
      lv  = int'(load_val);
      for (int i = 0; i < 2; i++) begin
         m_tc[i] = 0;
         if (load) begin
            m_cnt[i] = (lv < lim) ? lv : lim;
            m_pre[i] = 0;
         end else if (en) begin
            if (m_pre[i] < d) begin
               m_pre[i] = m_pre[i] + 1;
            end else begin
               m_pre[i] = 0;
               if (up_down) begin
                  if (m_cnt[i] >= lim) begin
                     m_cnt[i] = (i == 1) ? lim : 0;
                     m_tc[i]  = 1;
                  end else begin
                     m_cnt[i] = m_cnt[i] + 1;
                  end
               end else begin
                  if (m_cnt[i] == 0) begin
                     m_cnt[i] = (i == 1) ? 0 : lim;
                     m_tc[i]  = 1;
                  end else begin
                     m_cnt[i] = m_cnt[i] - 1;
                  end
               end
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #2;
      chk("model_wrap_count", int'(cnt_w), m_cnt[0]);
      chk("model_wrap_tc",    int'(tc_w),  m_tc[0]);
      chk("model_sat_count",  int'(cnt_s), m_cnt[1]);
      chk("model_sat_tc",     int'(tc_s),  m_tc[1]);
   endtask

   task automatic add(input logic e, input logic ud, input logic ld, input int lv,
                      input int lim, input int dv, input int cw, input int tw,
                      input int cs, input int ts);
      vec_t v;
      v.en = e;  v.ud = ud; v.ld = ld;
      v.lv = W'(lv); v.lim = W'(lim); v.dv = DW'(dv);
      v.cw = cw; v.tw = tw; v.cs = cs; v.ts = ts;
      tbl.push_back(v);
   endtask

   initial begin
      for (int k = 1; k <= 9; k++) add(1, 1, 0, 0, 9, 0, k, 0, k, 0);
      add(1, 1, 0, 0,  9, 0, 0, 1, 9, 1);
      add(1, 0, 0, 0,  9, 0, 9, 1, 8, 0);
      add(1, 0, 0, 0,  9, 0, 8, 0, 7, 0);
      add(1, 0, 1, 12, 9, 0, 9, 0, 9, 0);
      add(1, 1, 1, 5,  9, 0, 5, 0, 5, 0);
      add(1, 1, 0, 0,  9, 0, 6, 0, 6, 0);
      add(0, 1, 0, 0,  9, 0, 6, 0, 6, 0);
      add(1, 1, 0, 0,  3, 0, 0, 1, 3, 1);
      add(1, 0, 0, 0,  3, 0, 3, 1, 2, 0);
      add(1, 1, 0, 0,  0, 0, 0, 1, 0, 1);
      add(1, 1, 0, 0,  0, 0, 0, 1, 0, 1);
      add(1, 0, 0, 0,  0, 0, 0, 1, 0, 1);
      add(1, 0, 1, 7,  9, 0, 7, 0, 7, 0);
      add(1, 0, 0, 0,  3, 0, 6, 0, 6, 0);

      // Async reset with no clock edge required.
      #1 reset = 1'b0;
      en = 1'b1; up_down = 1'b1; div = '0; limit = 8'd9;
      #11;
      chk("reset_wrap_count", int'(cnt_w), 0);
      chk("reset_wrap_tc",    int'(tc_w),  0);
      chk("reset_sat_count",  int'(cnt_s), 0);
      chk("reset_sat_tc",     int'(tc_s),  0);
      #10 reset = 1'b1;
      model_reset();

      foreach (tbl[i]) begin
         en = tbl[i].en; up_down = tbl[i].ud; load = tbl[i].ld;
         load_val = tbl[i].lv; limit = tbl[i].lim; div = tbl[i].dv;
         step();
         chk($sformatf("tbl%0d_wrap_count", i), int'(cnt_w), tbl[i].cw);
         chk($sformatf("tbl%0d_wrap_tc", i),    int'(tc_w),  tbl[i].tw);
         chk($sformatf("tbl%0d_sat_count", i),  int'(cnt_s), tbl[i].cs);
         chk($sformatf("tbl%0d_sat_tc", i),     int'(tc_s),  tbl[i].ts);
      end

      // Prescaler div=3, then a 10-cycle freeze and resume.
      load = 1'b1; load_val = '0; limit = 8'd9; div = DW'(3); en = 1'b1; up_down = 1'b1;
      step();
      load = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("div3_hold", int'(cnt_w), 0);
      end
      step();
      chk("div3_first_step", int'(cnt_w), 1);
      step();
      step();
      en = 1'b0;
      for (int k = 0; k < 10; k++) step();
      chk("freeze_count", int'(cnt_w), 1);
      en = 1'b1;
      step();
      chk("resume_phase_hold", int'(cnt_w), 1);
      step();
      chk("resume_step", int'(cnt_w), 2);

      // Saturate at top with repeated tc, then at zero going down.
      div = '0; load = 1'b1; load_val = 8'd14; limit = 8'd15;
      step();
      load = 1'b0;
      step();
      chk("sat_reach_top", int'(cnt_s), 15);
      chk("sat_reach_tc",  int'(tc_s),  0);
      for (int k = 0; k < 2; k++) begin
         step();
         chk("sat_hold_top", int'(cnt_s), 15);
         chk("sat_hold_tc",  int'(tc_s),  1);
      end
      load = 1'b1; load_val = '0;
      step();
      load = 1'b0; up_down = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("sat_hold_zero", int'(cnt_s), 0);
         chk("sat_zero_tc",   int'(tc_s),  1);
      end

      // Randomized traffic against the reference model.
      for (int k = 0; k < 400; k++) begin
         en       = ($urandom % 8) != 0;
         up_down  = 1'($urandom % 2);
         load     = ($urandom % 16) == 0;
         load_val = W'($urandom % 256);
         if ($urandom % 32 == 0)
            limit = ($urandom % 4 == 0) ? W'($urandom % 4) : W'($urandom % 256);
         if ($urandom % 32 == 0)
            div = DW'($urandom % 4);
         step();
      end

      // Reset mid-count between edges, with sat instance at 7 and tc high.
      en = 1'b1; div = '0; up_down = 1'b1; load = 1'b1; load_val = 8'd7; limit = 8'd7;
      step();
      load = 1'b0;
      step();
      chk("pre_reset_sat_count", int'(cnt_s), 7);
      chk("pre_reset_sat_tc",    int'(tc_s),  1);
      #3 reset = 1'b0;
      #1;
      chk("async_reset_sat_count", int'(cnt_s), 0);
      chk("async_reset_sat_tc",    int'(tc_s),  0);
      chk("async_reset_wrap_tc",   int'(tc_w),  0);
      #10;
      chk("reset_held_count", int'(cnt_s), 0);
      reset = 1'b1;
      model_reset();
      step();
      chk("restart_count", int'(cnt_s), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
